// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: decoded fields flowing into EX and the stage's status back to IF/ID.
// master drives the decode side, slave is the pipeline register itself.
interface id_ex_stage_if #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic [4:0]        in_rs_id;
    logic [4:0]        in_rt_id;
    logic              in_uses_rs;
    logic              in_uses_rt;
    logic [4:0]        in_dest_id;
    logic [31:0]       in_rs_value;
    logic [31:0]       in_rt_value;
    logic [31:0]       in_imm;
    logic [CTRL_W-1:0] in_ctrl;
    logic              in_mem_read;
    logic              in_reg_write;
    logic              flush;
    logic              ex_stall;

    logic              out_valid;
    logic [4:0]        out_rs_id;
    logic [4:0]        out_rt_id;
    logic [4:0]        out_dest_id;
    logic [31:0]       out_rs_value;
    logic [31:0]       out_rt_value;
    logic [31:0]       out_imm;
    logic [CTRL_W-1:0] out_ctrl;
    logic              out_mem_read;
    logic              out_reg_write;
    logic              stall_id;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output in_valid, in_rs_id, in_rt_id, in_uses_rs, in_uses_rt, in_dest_id,
               in_rs_value, in_rt_value, in_imm, in_ctrl, in_mem_read, in_reg_write,
               flush, ex_stall,
        input  out_valid, out_rs_id, out_rt_id, out_dest_id, out_rs_value, out_rt_value,
               out_imm, out_ctrl, out_mem_read, out_reg_write, stall_id, bubble_count
    );

    modport slave (
        input  in_valid, in_rs_id, in_rt_id, in_uses_rs, in_uses_rt, in_dest_id,
               in_rs_value, in_rt_value, in_imm, in_ctrl, in_mem_read, in_reg_write,
               flush, ex_stall,
        output out_valid, out_rs_id, out_rt_id, out_dest_id, out_rs_value, out_rt_value,
               out_imm, out_ctrl, out_mem_read, out_reg_write, stall_id, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush, EX backpressure
// and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    id_ex_stage_if.slave  bus
);

    logic              out_valid_q,     out_valid_d;
    logic [4:0]        out_rs_id_q,     out_rs_id_d;
    logic [4:0]        out_rt_id_q,     out_rt_id_d;
    logic [4:0]        out_dest_id_q,   out_dest_id_d;
    logic [31:0]       out_rs_value_q,  out_rs_value_d;
    logic [31:0]       out_rt_value_q,  out_rt_value_d;
    logic [31:0]       out_imm_q,       out_imm_d;
    logic [CTRL_W-1:0] out_ctrl_q,      out_ctrl_d;
    logic              out_mem_read_q,  out_mem_read_d;
    logic              out_reg_write_q, out_reg_write_d;
    logic [CNT_W-1:0]  bubble_count_q,  bubble_count_d;

    logic rs_match;
    logic rt_match;
    logic hazard;
    logic load_in_ex;

    // A load writing $0 never produces a value anyone waits on, so it cannot cause a hazard.
    always_comb begin
        load_in_ex = out_valid_q & out_mem_read_q & (out_dest_id_q != 5'd0);
        rs_match   = bus.in_uses_rs & (bus.in_rs_id == out_dest_id_q);
        rt_match   = bus.in_uses_rt & (bus.in_rt_id == out_dest_id_q);
        hazard     = load_in_ex & bus.in_valid & (rs_match | rt_match);
    end

    // Gated with reset_n so IF/ID is never told to hold while the pipeline is being cleared.
    assign bus.stall_id = reset_n & ~bus.flush & ((bus.ex_stall & bus.in_valid) | hazard);

    always_comb begin
        out_valid_d     = out_valid_q;
        out_rs_id_d     = out_rs_id_q;
        out_rt_id_d     = out_rt_id_q;
        out_dest_id_d   = out_dest_id_q;
        out_rs_value_d  = out_rs_value_q;
        out_rt_value_d  = out_rt_value_q;
        out_imm_d       = out_imm_q;
        out_ctrl_d      = out_ctrl_q;
        out_mem_read_d  = out_mem_read_q;
        out_reg_write_d = out_reg_write_q;
        bubble_count_d  = bubble_count_q;

        if (bus.flush || (!bus.ex_stall && hazard)) begin
            out_valid_d     = 1'b0;
            out_rs_id_d     = '0;
            out_rt_id_d     = '0;
            out_dest_id_d   = '0;
            out_rs_value_d  = '0;
            out_rt_value_d  = '0;
            out_imm_d       = '0;
            out_ctrl_d      = '0;
            out_mem_read_d  = 1'b0;
            out_reg_write_d = 1'b0;
            // Only a genuine load-use bubble counts; a squash is not a bubble.
            if (!bus.flush && (bubble_count_q != {CNT_W{1'b1}})) begin
                bubble_count_d = bubble_count_q + CNT_W'(1);
            end
        end else if (!bus.ex_stall) begin
            out_valid_d     = bus.in_valid;
            out_rs_id_d     = bus.in_rs_id;
            out_rt_id_d     = bus.in_rt_id;
            out_dest_id_d   = bus.in_dest_id;
            out_rs_value_d  = bus.in_rs_value;
            out_rt_value_d  = bus.in_rt_value;
            out_imm_d       = bus.in_imm;
            out_ctrl_d      = bus.in_ctrl;
            out_mem_read_d  = bus.in_mem_read & bus.in_valid;
            out_reg_write_d = bus.in_reg_write & bus.in_valid & (bus.in_dest_id != 5'd0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q     <= 1'b0;
            out_rs_id_q     <= '0;
            out_rt_id_q     <= '0;
            out_dest_id_q   <= '0;
            out_rs_value_q  <= '0;
            out_rt_value_q  <= '0;
            out_imm_q       <= '0;
            out_ctrl_q      <= '0;
            out_mem_read_q  <= 1'b0;
            out_reg_write_q <= 1'b0;
            bubble_count_q  <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            out_rs_id_q     <= out_rs_id_d;
            out_rt_id_q     <= out_rt_id_d;
            out_dest_id_q   <= out_dest_id_d;
            out_rs_value_q  <= out_rs_value_d;
            out_rt_value_q  <= out_rt_value_d;
            out_imm_q       <= out_imm_d;
            out_ctrl_q      <= out_ctrl_d;
            out_mem_read_q  <= out_mem_read_d;
            out_reg_write_q <= out_reg_write_d;
            bubble_count_q  <= bubble_count_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_rs_id     = out_rs_id_q;
    assign bus.out_rt_id     = out_rt_id_q;
    assign bus.out_dest_id   = out_dest_id_q;
    assign bus.out_rs_value  = out_rs_value_q;
    assign bus.out_rt_value  = out_rt_value_q;
    assign bus.out_imm       = out_imm_q;
    assign bus.out_ctrl      = out_ctrl_q;
    assign bus.out_mem_read  = out_mem_read_q;
    assign bus.out_reg_write = out_reg_write_q;
    assign bus.bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts EX contents each cycle,
// a second instance with a 2-bit counter covers saturation.
module tb_id_ex_stage;

    logic clock;
    logic reset_n;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    id_ex_stage_if #(.CTRL_W(8), .CNT_W(16)) bus16 ();
    id_ex_stage_if #(.CTRL_W(8), .CNT_W(2))  bus2 ();

    id_ex_stage #(.CTRL_W(8), .CNT_W(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus16)
    );

    id_ex_stage #(.CTRL_W(8), .CNT_W(2)) dut_sat (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs_id;
        logic [4:0]  rt_id;
        logic        uses_rs;
        logic        uses_rt;
        logic [4:0]  dest_id;
        logic [31:0] rs_value;
        logic [31:0] rt_value;
        logic [31:0] imm;
        logic [7:0]  ctrl;
        logic        mem_read;
        logic        reg_write;
        logic        flush;
        logic        ex_stall;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic        mem_read;
        logic        reg_write;
        logic [7:0]  ctrl;
        logic [4:0]  rs_id;
        logic [4:0]  rt_id;
        logic [4:0]  dest_id;
        logic [31:0] rs_value;
        logic [31:0] rt_value;
        logic [31:0] imm;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic        data_care;
    } exp_t;

    exp_t  model;
    exp_t  sb_q[$];
    int    n_compared;
    int    n_mismatched;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic stim_t mkInstr(input logic valid, input logic [4:0] rs, input logic uses_rs,
                                      input logic [4:0] rt, input logic uses_rt, input logic [4:0] dest,
                                      input logic mem_read, input logic reg_write);
        stim_t s;
        s           = '0;
        s.valid     = valid;
        s.rs_id     = rs;
        s.uses_rs   = uses_rs;
        s.rt_id     = rt;
        s.uses_rt   = uses_rt;
        s.dest_id   = dest;
        s.mem_read  = mem_read;
        s.reg_write = reg_write;
        s.rs_value  = $urandom;
        s.rt_value  = $urandom;
        s.imm       = $urandom;
        s.ctrl      = 8'($urandom);
        return s;
    endfunction

    task automatic driveInputs(input stim_t s);
        bus16.in_valid     = s.valid;     bus2.in_valid     = s.valid;
        bus16.in_rs_id     = s.rs_id;     bus2.in_rs_id     = s.rs_id;
        bus16.in_rt_id     = s.rt_id;     bus2.in_rt_id     = s.rt_id;
        bus16.in_uses_rs   = s.uses_rs;   bus2.in_uses_rs   = s.uses_rs;
        bus16.in_uses_rt   = s.uses_rt;   bus2.in_uses_rt   = s.uses_rt;
        bus16.in_dest_id   = s.dest_id;   bus2.in_dest_id   = s.dest_id;
        bus16.in_rs_value  = s.rs_value;  bus2.in_rs_value  = s.rs_value;
        bus16.in_rt_value  = s.rt_value;  bus2.in_rt_value  = s.rt_value;
        bus16.in_imm       = s.imm;       bus2.in_imm       = s.imm;
        bus16.in_ctrl      = s.ctrl;      bus2.in_ctrl      = s.ctrl;
        bus16.in_mem_read  = s.mem_read;  bus2.in_mem_read  = s.mem_read;
        bus16.in_reg_write = s.reg_write; bus2.in_reg_write = s.reg_write;
        bus16.flush        = s.flush;     bus2.flush        = s.flush;
        bus16.ex_stall     = s.ex_stall;  bus2.ex_stall     = s.ex_stall;
    endtask

    task automatic checkRegs(input string tag, input exp_t e);
        checkOutput({tag, ".valid"},     64'(bus16.out_valid),     64'(e.valid));
        checkOutput({tag, ".mem_read"},  64'(bus16.out_mem_read),  64'(e.mem_read));
        checkOutput({tag, ".reg_write"}, 64'(bus16.out_reg_write), 64'(e.reg_write));
        checkOutput({tag, ".count"},     64'(bus16.bubble_count),  64'(e.cnt));
        checkOutput({tag, ".count2"},    64'(bus2.bubble_count),   64'(e.cnt2));
        if (e.data_care) begin
            checkOutput({tag, ".ctrl"},     64'(bus16.out_ctrl),     64'(e.ctrl));
            checkOutput({tag, ".rs_id"},    64'(bus16.out_rs_id),    64'(e.rs_id));
            checkOutput({tag, ".rt_id"},    64'(bus16.out_rt_id),    64'(e.rt_id));
            checkOutput({tag, ".dest_id"},  64'(bus16.out_dest_id),  64'(e.dest_id));
            checkOutput({tag, ".rs_value"}, 64'(bus16.out_rs_value), 64'(e.rs_value));
            checkOutput({tag, ".rt_value"}, 64'(bus16.out_rt_value), 64'(e.rt_value));
            checkOutput({tag, ".imm"},      64'(bus16.out_imm),      64'(e.imm));
        end
    endtask

    function automatic exp_t resetModel();
        exp_t e;
        e           = '0;
        e.data_care = 1'b1;
        return e;
    endfunction

    // One cycle: drive at negedge, check stall_id, predict, then compare after the posedge.
    task automatic applyStimulus(input string tag, input stim_t s);
        exp_t nxt;
        exp_t got;
        logic hz;
        logic exp_stall;
        @(negedge clock);
        driveInputs(s);
        #1;
        hz = model.valid && model.mem_read && (model.dest_id != 5'd0) && s.valid &&
             ((s.uses_rs && (s.rs_id == model.dest_id)) || (s.uses_rt && (s.rt_id == model.dest_id)));
        exp_stall = !s.flush && ((s.ex_stall && s.valid) || hz);
        checkOutput({tag, ".stall_id"}, 64'(bus16.stall_id), 64'(exp_stall));

        nxt = model;
        if (s.flush) begin
            nxt      = resetModel();
            nxt.cnt  = model.cnt;
            nxt.cnt2 = model.cnt2;
        end else if (s.ex_stall) begin
            nxt = model;
        end else if (hz) begin
            nxt      = resetModel();
            nxt.cnt  = (model.cnt == 16'hFFFF) ? model.cnt : model.cnt + 16'd1;
            nxt.cnt2 = (model.cnt2 == 2'd3) ? model.cnt2 : model.cnt2 + 2'd1;
        end else begin
            nxt.valid     = s.valid;
            nxt.mem_read  = s.mem_read & s.valid;
            nxt.reg_write = s.reg_write & s.valid & (s.dest_id != 5'd0);
            nxt.ctrl      = s.ctrl;
            nxt.rs_id     = s.rs_id;
            nxt.rt_id     = s.rt_id;
            nxt.dest_id   = s.dest_id;
            nxt.rs_value  = s.rs_value;
            nxt.rt_value  = s.rt_value;
            nxt.imm       = s.imm;
            nxt.data_care = s.valid;
        end
        model = nxt;
        sb_q.push_back(nxt);

        @(posedge clock);
        #1;
        got = sb_q.pop_front();
        checkRegs(tag, got);
    endtask

    task automatic resetMidCycle();
        stim_t s;
        s          = mkInstr(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b0, 1'b1);
        s.ex_stall = 1'b1;
        @(negedge clock);
        driveInputs(s);
        #2;
        reset_n = 1'b0;
        #1;
        model = resetModel();
        checkOutput("midreset.stall_id", 64'(bus16.stall_id), 64'd0);
        checkRegs("midreset", model);
        @(posedge clock);
        @(negedge clock);
        driveInputs('0);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        stim_t ld;
        n_compared   = 0;
        n_mismatched = 0;
        model        = resetModel();

        // Reset held with random traffic, including a would-be stall request.
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s          = mkInstr(1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 1'b1);
            s.ex_stall = 1'b1;
            driveInputs(s);
            @(negedge clock);
            checkOutput("inreset.stall_id", 64'(bus16.stall_id), 64'd0);
            checkOutput("inreset.valid", 64'(bus16.out_valid), 64'd0);
        end
        driveInputs('0);
        reset_n = 1'b1;
        #1;
        checkRegs("reset", model);

        s          = mkInstr(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd5, 1'b0, 1'b1);
        s.rs_value = 32'h1234;
        applyStimulus("first_load", s);
        checkOutput("first_load.rs_value_const", 64'(bus16.out_rs_value), 64'h1234);

        // Load-use on rs: one bubble, then the same instruction goes through.
        ld = mkInstr(1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 5'd8, 1'b1, 1'b1);
        applyStimulus("lw8", ld);
        s = mkInstr(1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 5'd11, 1'b0, 1'b1);
        applyStimulus("use8", s);
        checkOutput("use8.count_const", 64'(bus16.bubble_count), 64'd1);
        applyStimulus("use8_retry", s);

        // Load to $0 followed by a $0 read must not stall.
        applyStimulus("lw0", mkInstr(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1));
        applyStimulus("use0", mkInstr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b0, 1'b1));

        // Matching rt that is not actually read must not stall.
        applyStimulus("lw8b", ld);
        applyStimulus("rt8_unused", mkInstr(1'b1, 5'd3, 1'b1, 5'd8, 1'b0, 5'd13, 1'b0, 1'b1));

        // Load-use on rt.
        applyStimulus("lw8c", ld);
        s = mkInstr(1'b1, 5'd4, 1'b0, 5'd8, 1'b1, 5'd14, 1'b0, 1'b1);
        applyStimulus("rt8_used", s);
        applyStimulus("rt8_retry", s);

        // Backpressure with changing inputs freezes EX.
        for (int i = 0; i < 3; i++) begin
            s          = mkInstr(1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b0, 1'b1);
            s.ex_stall = 1'b1;
            applyStimulus("ex_stall", s);
        end

        s          = mkInstr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1);
        s.ex_stall = 1'b1;
        s.flush    = 1'b1;
        applyStimulus("stall_flush", s);

        // Flush while a load-use hazard is pending.
        applyStimulus("lw9", mkInstr(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd9, 1'b1, 1'b1));
        s          = mkInstr(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd15, 1'b0, 1'b1);
        s.ex_stall = 1'b1;
        s.flush    = 1'b1;
        applyStimulus("flush_hazard", s);

        applyStimulus("dest0_write", mkInstr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1));
        applyStimulus("invalid_in", mkInstr(1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b1));

        resetMidCycle();

        // Five bubbles from a clean counter: the 2-bit copy reads 1,2,3,3,3.
        for (int i = 0; i < 5; i++) begin
            applyStimulus("sat_lw", mkInstr(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd10, 1'b1, 1'b1));
            s = mkInstr(1'b1, 5'd10, 1'b1, 5'd2, 1'b0, 5'd16, 1'b0, 1'b1);
            applyStimulus("sat_use", s);
            checkOutput("sat_seq", 64'(bus2.bubble_count), 64'((i >= 2) ? 3 : i + 1));
            applyStimulus("sat_retry", s);
        end

        checkOutput("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
